// File: rtl/ram_block_mover_pkg.sv
// rtl/ram_block_mover_pkg.sv - shared state encoding and mode constants for the RAM block mover
package ram_block_mover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_block_mover.sv
// rtl/ram_block_mover.sv - block copy / block fill engine driving one single-port RAM port
// Address and write enable are registered; ram_data is a mux of ram_q and the latched fill value.
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int address_width = 8,
  parameter int data_width    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [address_width-1:0] src_addr,
  input  logic [address_width-1:0] dst_addr,
  input  logic [address_width:0]   length,
  input  logic [data_width-1:0]    fill_data,
  output logic                     busy,
  output logic                     done,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q
);

  localparam logic [address_width-1:0] PTR_ONE = {{(address_width-1){1'b0}}, 1'b1};
  localparam logic [address_width:0]   CNT_ONE = {{address_width{1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [address_width-1:0] src_ptr_q, src_ptr_d;
  logic [address_width-1:0] dst_ptr_q, dst_ptr_d;
  logic [address_width:0]   count_q, count_d;
  logic                     mode_q, mode_d;
  logic [data_width-1:0]    fill_q, fill_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic                     wren_q, wren_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Outputs for the next cycle are decided here, so the RAM sees them straight from flops.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    addr_d    = addr_q;
    wren_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          fill_d    = fill_data;
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          count_d   = length;
          if (length == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (mode == MODE_COPY) begin
            state_d = ST_READ;
            addr_d  = src_addr;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_FILL;
            addr_d  = dst_addr;
            wren_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      ST_READ: begin
        state_d = ST_WRITE;
        addr_d  = dst_ptr_q;
        wren_d  = 1'b1;
      end

      ST_WRITE: begin
        src_ptr_d = src_ptr_q + PTR_ONE;
        dst_ptr_d = dst_ptr_q + PTR_ONE;
        count_d   = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_READ;
          addr_d  = src_ptr_q + PTR_ONE;
        end
      end

      ST_FILL: begin
        dst_ptr_d = dst_ptr_q + PTR_ONE;
        count_d   = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          addr_d = dst_ptr_q + PTR_ONE;
          wren_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      mode_q    <= MODE_COPY;
      fill_q    <= '0;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_address = addr_q;
  assign ram_wren    = wren_q;
  // In copy mode the word read one cycle earlier is forwarded straight to the write port.
  assign ram_data    = (mode_q == MODE_FILL) ? fill_q : ram_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// tb/tb_ram_block_mover.sv - directed self-checking bench for ram_block_mover with a single-port RAM model
module tb_ram_block_mover;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] length;
  logic [7:0] fill_data;
  logic       busy;
  logic       done;
  logic [7:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;

  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] ram_mem [0:255];

  logic       cap_wren [0:320];
  logic       cap_busy [0:320];
  logic       cap_done [0:320];
  logic [7:0] cap_addr [0:320];
  logic [7:0] cap_data [0:320];

  int tests_run;
  int tests_failed;

  ram_block_mover #(.address_width(8), .data_width(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic preload_ram();
    for (int i = 0; i < 256; i++) write_word(8'(i), 8'((i * 7 + 3) & 255));
  endtask

  // Issues one command and records outputs for each cycle after acceptance (cycle 1 onward).
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] len, input logic [7:0] f,
                         input int inj_cyc, input logic [7:0] inj_dst, input logic [8:0] inj_len,
                         input logic [7:0] inj_fill, input int rst_cyc,
                         output int done_cyc, output int n_cyc);
    @(negedge clock);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_data = f;
    @(negedge clock);
    done_cyc = 0;
    n_cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      cap_wren[c] = ram_wren; cap_busy[c] = busy; cap_done[c] = done;
      cap_addr[c] = ram_address; cap_data[c] = ram_data;
      if (done && done_cyc == 0) done_cyc = c;
      n_cyc = c;
      if (c == inj_cyc) begin
        start = 1'b1; mode = 1'b1; src_addr = 8'h00; dst_addr = inj_dst;
        length = inj_len; fill_data = inj_fill;
      end else begin
        start = 1'b0; mode = ~m; src_addr = 8'h5C; dst_addr = 8'hC5;
        length = 9'h0AA; fill_data = 8'hFF;
      end
      reset = (c == rst_cyc);
      if (done_cyc != 0 && c >= done_cyc + 4 && c > inj_cyc + 3) break;
      if (rst_cyc != 0 && c >= rst_cyc + 4) break;
      @(negedge clock);
    end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (ram_wren !== 1'b0) begin tests_failed++; $display("FAIL reset_wren got %b want 0", ram_wren); end
    tests_run++; if (ram_address !== 8'h00) begin tests_failed++; $display("FAIL reset_addr got %h want 00", ram_address); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fill();
    int dc, nc;
    run_cmd(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5, 0, 8'h00, 9'd0, 8'h00, 0, dc, nc);
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (cap_wren[c] !== 1'b1 || cap_addr[c] !== 8'(8'h10 + c - 1) || cap_data[c] !== 8'hA5 || cap_busy[c] !== 1'b1)
        begin tests_failed++; $display("FAIL fill_cycle%0d got wren=%b addr=%h data=%h busy=%b want 1/%h/a5/1", c, cap_wren[c], cap_addr[c], cap_data[c], cap_busy[c], 8'(8'h10 + c - 1)); end
    end
    tests_run++; if (dc !== 5) begin tests_failed++; $display("FAIL fill_done_cycle got %0d want 5", dc); end
    tests_run++;
    if (cap_wren[5] !== 1'b0 || cap_busy[5] !== 1'b0 || cap_done[6] !== 1'b0)
      begin tests_failed++; $display("FAIL fill_done_shape got wren=%b busy=%b done6=%b want 0/0/0", cap_wren[5], cap_busy[5], cap_done[6]); end
    for (int a = 16; a < 20; a++) begin
      tests_run++; if (ram_mem[a] !== 8'hA5) begin tests_failed++; $display("FAIL fill_mem[%h] got %h want a5", a, ram_mem[a]); end
    end
    tests_run++; if (ram_mem[8'h0F] !== 8'h6C) begin tests_failed++; $display("FAIL fill_mem_below got %h want 6c", ram_mem[8'h0F]); end
    tests_run++; if (ram_mem[8'h14] !== 8'h8F) begin tests_failed++; $display("FAIL fill_mem_above got %h want 8f", ram_mem[8'h14]); end
  endtask

  task automatic test_copy();
    int dc, nc;
    logic [7:0] exp_addr [0:5];
    logic       exp_wren [0:5];
    logic [7:0] exp_mem  [0:2];
    exp_addr = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 8'h82};
    exp_wren = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_mem  = '{8'h01, 8'h02, 8'h03};
    write_word(8'h00, 8'h01); write_word(8'h01, 8'h02); write_word(8'h02, 8'h03);
    run_cmd(1'b0, 8'h00, 8'h80, 9'd3, 8'h00, 0, 8'h00, 9'd0, 8'h00, 0, dc, nc);
    for (int c = 1; c <= 6; c++) begin
      tests_run++;
      if (cap_addr[c] !== exp_addr[c-1] || cap_wren[c] !== exp_wren[c-1])
        begin tests_failed++; $display("FAIL copy_cycle%0d got addr=%h wren=%b want %h/%b", c, cap_addr[c], cap_wren[c], exp_addr[c-1], exp_wren[c-1]); end
    end
    tests_run++; if (cap_data[4] !== 8'h02) begin tests_failed++; $display("FAIL copy_wdata got %h want 02", cap_data[4]); end
    tests_run++; if (dc !== 7) begin tests_failed++; $display("FAIL copy_done_cycle got %0d want 7", dc); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (ram_mem[8'h80 + i] !== exp_mem[i]) begin tests_failed++; $display("FAIL copy_mem[%h] got %h want %h", 8'h80 + i, ram_mem[8'h80 + i], exp_mem[i]); end
    end
    tests_run++; if (ram_mem[8'h83] !== 8'h98) begin tests_failed++; $display("FAIL copy_mem_above got %h want 98", ram_mem[8'h83]); end
  endtask

  task automatic test_wrap_fill();
    int dc, nc;
    logic [7:0] exp_addr [0:2];
    exp_addr = '{8'hFE, 8'hFF, 8'h00};
    run_cmd(1'b1, 8'h00, 8'hFE, 9'd3, 8'h5A, 0, 8'h00, 9'd0, 8'h00, 0, dc, nc);
    for (int c = 1; c <= 3; c++) begin
      tests_run++;
      if (cap_wren[c] !== 1'b1 || cap_addr[c] !== exp_addr[c-1])
        begin tests_failed++; $display("FAIL wrap_cycle%0d got wren=%b addr=%h want 1/%h", c, cap_wren[c], cap_addr[c], exp_addr[c-1]); end
    end
    tests_run++; if (dc !== 4) begin tests_failed++; $display("FAIL wrap_done_cycle got %0d want 4", dc); end
    tests_run++;
    if (ram_mem[8'hFE] !== 8'h5A || ram_mem[8'hFF] !== 8'h5A || ram_mem[8'h00] !== 8'h5A)
      begin tests_failed++; $display("FAIL wrap_mem got %h %h %h want 5a 5a 5a", ram_mem[8'hFE], ram_mem[8'hFF], ram_mem[8'h00]); end
    tests_run++; if (ram_mem[8'h01] !== 8'h02) begin tests_failed++; $display("FAIL wrap_mem_01 got %h want 02", ram_mem[8'h01]); end
    tests_run++; if (ram_mem[8'hFD] !== 8'hEE) begin tests_failed++; $display("FAIL wrap_mem_fd got %h want ee", ram_mem[8'hFD]); end
  endtask

  task automatic test_zero_length();
    int dc, nc, wr;
    // A second start lands in the DONE cycle and must be ignored.
    run_cmd(1'b1, 8'h00, 8'h05, 9'd0, 8'h99, 1, 8'h05, 9'd1, 8'h66, 0, dc, nc);
    tests_run++; if (dc !== 1) begin tests_failed++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
    tests_run++; if (cap_busy[1] !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got %b want 0", cap_busy[1]); end
    wr = 0;
    for (int c = 1; c <= nc; c++) if (cap_wren[c] !== 1'b0 || (c > 1 && cap_busy[c] !== 1'b0)) wr++;
    tests_run++; if (wr !== 0) begin tests_failed++; $display("FAIL zero_no_activity got %0d active cycles want 0", wr); end
    tests_run++; if (ram_mem[8'h05] !== 8'h26) begin tests_failed++; $display("FAIL zero_mem_05 got %h want 26", ram_mem[8'h05]); end
  endtask

  task automatic test_full_fill();
    int dc, nc, wr, bad;
    int hits [0:255];
    for (int a = 0; a < 256; a++) hits[a] = 0;
    run_cmd(1'b1, 8'h00, 8'h37, 9'd256, 8'hC3, 0, 8'h00, 9'd0, 8'h00, 0, dc, nc);
    wr = 0;
    for (int c = 1; c <= nc; c++) if (cap_wren[c] === 1'b1) begin wr++; hits[cap_addr[c]]++; end
    tests_run++; if (wr !== 256) begin tests_failed++; $display("FAIL full_write_count got %0d want 256", wr); end
    bad = 0;
    for (int a = 0; a < 256; a++) if (hits[a] != 1 || ram_mem[a] !== 8'hC3) bad++;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL full_each_once got %0d bad addresses want 0", bad); end
    tests_run++; if (cap_addr[1] !== 8'h37) begin tests_failed++; $display("FAIL full_first_addr got %h want 37", cap_addr[1]); end
    tests_run++; if (dc !== 257) begin tests_failed++; $display("FAIL full_done_cycle got %0d want 257", dc); end
  endtask

  task automatic test_overlap_copy();
    int dc, nc;
    logic [7:0] exp_addr [0:5];
    exp_addr = '{8'h20, 8'h21, 8'h21, 8'h22, 8'h22, 8'h23};
    write_word(8'h20, 8'h11); write_word(8'h21, 8'h22); write_word(8'h22, 8'h33);
    // A start while busy tries to fill address 00; it must have no effect.
    run_cmd(1'b0, 8'h20, 8'h21, 9'd3, 8'h00, 2, 8'h00, 9'd1, 8'h77, 0, dc, nc);
    for (int c = 1; c <= 6; c++) begin
      tests_run++;
      if (cap_addr[c] !== exp_addr[c-1] || cap_wren[c] !== 1'(c % 2 == 0))
        begin tests_failed++; $display("FAIL overlap_cycle%0d got addr=%h wren=%b want %h/%b", c, cap_addr[c], cap_wren[c], exp_addr[c-1], 1'(c % 2 == 0)); end
    end
    tests_run++; if (dc !== 7) begin tests_failed++; $display("FAIL overlap_done_cycle got %0d want 7", dc); end
    tests_run++;
    if (ram_mem[8'h20] !== 8'h11 || ram_mem[8'h21] !== 8'h11 || ram_mem[8'h22] !== 8'h11 || ram_mem[8'h23] !== 8'h11)
      begin tests_failed++; $display("FAIL overlap_mem got %h %h %h %h want 11 11 11 11", ram_mem[8'h20], ram_mem[8'h21], ram_mem[8'h22], ram_mem[8'h23]); end
    tests_run++; if (ram_mem[8'h00] !== 8'hC3) begin tests_failed++; $display("FAIL overlap_ignored_start got %h want c3", ram_mem[8'h00]); end
  endtask

  task automatic test_reset_mid_fill();
    int dc, nc, bad;
    run_cmd(1'b1, 8'h00, 8'h40, 9'd8, 8'h99, 0, 8'h00, 9'd0, 8'h00, 3, dc, nc);
    tests_run++;
    if (cap_wren[4] !== 1'b0 || cap_busy[4] !== 1'b0 || cap_addr[4] !== 8'h00)
      begin tests_failed++; $display("FAIL rstmid_after got wren=%b busy=%b addr=%h want 0/0/00", cap_wren[4], cap_busy[4], cap_addr[4]); end
    bad = 0;
    for (int c = 4; c <= nc; c++) if (cap_wren[c] !== 1'b0 || cap_done[c] !== 1'b0) bad++;
    tests_run++; if (bad !== 0 || dc !== 0) begin tests_failed++; $display("FAIL rstmid_quiet got %0d active cycles done_cycle=%0d want 0/0", bad, dc); end
    tests_run++;
    if (ram_mem[8'h40] !== 8'h99 || ram_mem[8'h41] !== 8'h99 || ram_mem[8'h42] !== 8'h99 || ram_mem[8'h43] !== 8'hC3)
      begin tests_failed++; $display("FAIL rstmid_mem got %h %h %h %h want 99 99 99 c3", ram_mem[8'h40], ram_mem[8'h41], ram_mem[8'h42], ram_mem[8'h43]); end
  endtask

  task automatic test_back_to_back();
    int dc, nc;
    // Second command is presented in the first IDLE cycle after DONE.
    run_cmd(1'b1, 8'h00, 8'h43, 9'd2, 8'h12, 4, 8'h60, 9'd1, 8'h44, 0, dc, nc);
    tests_run++; if (dc !== 3) begin tests_failed++; $display("FAIL b2b_first_done got %0d want 3", dc); end
    tests_run++;
    if (cap_wren[4] !== 1'b0 || cap_busy[4] !== 1'b0)
      begin tests_failed++; $display("FAIL b2b_idle got wren=%b busy=%b want 0/0", cap_wren[4], cap_busy[4]); end
    tests_run++;
    if (cap_wren[5] !== 1'b1 || cap_addr[5] !== 8'h60 || cap_busy[5] !== 1'b1 || cap_data[5] !== 8'h44)
      begin tests_failed++; $display("FAIL b2b_second_write got wren=%b addr=%h busy=%b data=%h want 1/60/1/44", cap_wren[5], cap_addr[5], cap_busy[5], cap_data[5]); end
    tests_run++; if (cap_done[6] !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_done got %b want 1", cap_done[6]); end
    tests_run++;
    if (ram_mem[8'h43] !== 8'h12 || ram_mem[8'h44] !== 8'h12 || ram_mem[8'h45] !== 8'hC3 || ram_mem[8'h60] !== 8'h44)
      begin tests_failed++; $display("FAIL b2b_mem got %h %h %h %h want 12 12 c3 44", ram_mem[8'h43], ram_mem[8'h44], ram_mem[8'h45], ram_mem[8'h60]); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    start = 1'b0; mode = 1'b0; src_addr = 8'h00; dst_addr = 8'h00;
    length = 9'd0; fill_data = 8'h00;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    test_reset();
    preload_ram();
    test_fill();
    test_copy();
    test_wrap_fill();
    test_zero_length();
    test_full_fill();
    test_overlap_copy();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Requester-side engine that drives the single-port RAM interface: address, data and write enable out, with registered read data back and 1-cycle read latency.
- Performs block copy (RAM to RAM) and block fill (constant to RAM) on command.
- Sits between the core's control logic (loaders, reset-time clearing, video buffer moves) and one RAM port.
- Has exclusive use of that port while busy.

Parameters:
- address_width, 8, RAM address width; the RAM holds 2**address_width words.
- data_width, 8, RAM word width.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; latched on start.
- src_addr  in  address_width  copy source base; latched on start.
- dst_addr  in  address_width  destination base; latched on start.
- length  in  address_width+1  number of words, 0..2**address_width; latched on start.
- fill_data  in  data_width  fill value; latched on start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the operation completes.
- ram_address  out  address_width  to RAM address.
- ram_data  out  data_width  to RAM data.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  data_width  from RAM q; registered, valid 1 cycle after the address is presented.

Behaviour:
- Reset: state IDLE; busy=0, done=0, ram_wren=0, ram_address=0, internal counters=0.
- A reset asserted mid-operation aborts the operation. Outputs take their reset values at that edge. No further writes occur and no done pulse is produced.
- State, address and wren are registered. ram_data is a combinational mux:
  - copy: ram_data = ram_q
  - fill: ram_data = latched fill value
- IDLE:
  - start=1 with length=0 -> DONE. No RAM access.
  - start=1, mode=0 -> READ.
  - start=1, mode=1 -> FILL.
  - Otherwise stay in IDLE, with ram_wren=0 and ram_address holding.
- READ (copy): ram_address=src pointer, ram_wren=0. Always moves to WRITE next cycle.
- WRITE (copy): ram_address=dst pointer, ram_wren=1, ram_data=ram_q (the word read in the prior cycle). Then:
  - Increment both pointers modulo 2**address_width.
  - Decrement remaining count.
  - remaining count becomes 0 -> DONE; otherwise -> READ.
- Copy throughput is 2 cycles per word.
- FILL: ram_address=dst pointer, ram_wren=1, ram_data=fill value.
  - Increment the dst pointer and decrement the count every cycle; count becomes 0 -> DONE.
  - Fill throughput is 1 word per cycle.
- DONE: ram_wren=0, done=1, busy=0 for exactly one cycle, then IDLE.
- Command acceptance:
  - start is ignored while not in IDLE.
  - start in the DONE cycle is ignored.
  - start in the first IDLE cycle after DONE is accepted.
- Wrap-around: pointers wrap from 2**address_width-1 to 0. length=2**address_width touches every address exactly once.
- Overlap: transfer is strictly ascending.
  - dst < src, or no overlap: exact copy.
  - dst > src within range: forward smear (source words already overwritten propagate). This is defined behaviour, not an error.
- Inputs other than start are don't-care after acceptance.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, READ, WRITE, FILL, DONE
  - mode constants: MODE_COPY=0, MODE_FILL=1
- No sub-module is needed; pointer and count registers live in this block.
- The bench pairs the block with the team's generic single-port RAM: address_width=8, data_width=8, preloaded via init_file.

Test Plan:
- Fill, mode=1, dst=0x10, length=4, fill_data=0xA5 -> ram_wren high for exactly 4 consecutive cycles at addresses 0x10..0x13. done pulses once in the 5th cycle after acceptance. RAM[0x10..0x13]=0xA5; RAM[0x0F] and RAM[0x14] unchanged.
- Copy, mode=0, src=0x00 holding 0x01,0x02,0x03, dst=0x80, length=3 -> address sequence 00,80,01,81,02,82 with wren 0,1,0,1,0,1. RAM[0x80..0x82]=01,02,03. done pulses in cycle 7.
- Wrap fill, dst=0xFE, length=3, fill_data=0x5A -> writes at FE, FF, 00. RAM[0x01] untouched.
- length=0 and length=256 -> zero-length: no wren, done pulses the cycle after start. Full-length fill: 256 writes, each address written once.
- Overlapping copy, src=0x20 holding 11,22,33, dst=0x21, length=3 -> RAM[0x21..0x23]=11,11,11. Also: start pulsed while busy is ignored, and the first operation completes unchanged.
- Reset asserted in the 3rd cycle of a length=8 fill at dst=0x40 -> next cycle ram_wren=0, busy=0, no done pulse. Only 0x40..0x42 are modified. A new start after reset operates normally.
